// File: rtl/sync_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_frame_pkg
// Description : Shared types and constants for the sync-word frame receiver.
// Revision    : 1.0
// ============================================================================
package sync_frame_pkg;

  // Receiver sequencing states
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_e;

  localparam int                  SYNC_LEN  = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1101;

endpackage : sync_frame_pkg
`default_nettype wire

// File: rtl/sync_word_matcher.sv
`default_nettype none
// ============================================================================
// Module      : sync_word_matcher
// Description : Shift-register history of accepted bits; flags the sync word
//               when the history plus the bit being accepted now matches.
// Revision    : 1.0
// ============================================================================
module sync_word_matcher
  import sync_frame_pkg::*;
(
  input  logic clk,
  input  logic rst,      // synchronous, active-low
  input  logic bit_i,
  input  logic valid_i,
  input  logic clear_i,
  output logic match_o
);

  logic [SYNC_LEN-1:0] hist_q;

  // Match looks at the incoming bit too, so detection happens on the edge
  // that accepts the last sync bit (overlapping search).
  assign match_o = valid_i && ({hist_q[SYNC_LEN-2:0], bit_i} == SYNC_WORD);

  // History shift register; clear wins over a shift
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
    end else if (valid_i) begin
      hist_q <= {hist_q[SYNC_LEN-2:0], bit_i};
    end
  end

endmodule : sync_word_matcher
`default_nettype wire

// File: rtl/sync_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : sync_frame_controller
// Description : Serial frame receiver: hunts for the sync word, captures a
//               fixed-length payload and even-parity bit, delivers good
//               payloads through a one-entry valid/ready buffer, tracks lock.
// Revision    : 1.0
// ============================================================================
module sync_frame_controller
  import sync_frame_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,   // 2..32
  parameter int LOCK_FRAMES  = 3    // 1..15
) (
  input  logic                    clk,
  input  logic                    rst,        // synchronous, active-low
  input  logic                    in_bit,
  input  logic                    in_valid,
  output logic [PAYLOAD_BITS-1:0] data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    locked,
  output logic                    parity_err,
  output logic                    overflow
);

  localparam int CNT_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_FRAMES);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [PAYLOAD_BITS-1:0] cap_q;
  logic                    par_q;
  logic [3:0]              good_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    out_valid_q;
  logic                    locked_q;
  logic                    perr_q;
  logic                    ovf_q;

  logic                    hunt_valid;
  logic                    sync_hit;
  logic                    buf_free_d;
  logic [3:0]              good_d;

  // Only HUNT feeds the detector; anything else, or a hit, wipes the history
  // so stale bits never contribute to the next detection.
  assign hunt_valid = in_valid && (state_q == HUNT);

  sync_word_matcher u_matcher (
    .clk     (clk),
    .rst     (rst),
    .bit_i   (in_bit),
    .valid_i (hunt_valid),
    .clear_i ((state_q != HUNT) || sync_hit),
    .match_o (sync_hit)
  );

  // Buffer can take a frame if empty or being drained on this same edge
  assign buf_free_d = !out_valid_q || out_ready;
  assign good_d     = (good_q == LOCK_MAX) ? LOCK_MAX : good_q + 4'd1;

  // Frame FSM, capture, parity, output buffer and lock tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      cap_q       <= '0;
      par_q       <= 1'b0;
      good_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      perr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            if (sync_hit) begin
              state_q <= PAYLOAD;
              cnt_q   <= '0;
              par_q   <= 1'b0;
            end
          end
          PAYLOAD: begin
            cap_q <= {cap_q[PAYLOAD_BITS-2:0], in_bit};
            par_q <= par_q ^ in_bit;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            state_q <= HUNT;
            if ((par_q ^ in_bit) == 1'b0) begin
              good_q   <= good_d;
              locked_q <= (good_d == LOCK_MAX);
              if (buf_free_d) begin
                data_q      <= cap_q;
                out_valid_q <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end else begin
              perr_q   <= 1'b1;
              good_q   <= '0;
              locked_q <= 1'b0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign out_valid  = out_valid_q;
  assign locked     = locked_q;
  assign parity_err = perr_q;
  assign overflow   = ovf_q;

endmodule : sync_frame_controller
`default_nettype wire

// File: tb/tb_sync_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_frame_controller
// Description : Directed and randomized bench with a frame-level reference
//               model for sync_frame_controller.
// Revision    : 1.0
// ============================================================================
module tb_sync_frame_controller;

  localparam int P = 8;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_bit;
  logic         in_valid;
  logic [P-1:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         locked;
  logic         parity_err;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 1'b0;

  // Reference model: last four accepted bits while hunting, and the bits of
  // the frame collected so far once the sync word has been seen.
  int           m_last4;
  bit           m_in_frame;
  logic         m_frame[$];
  logic [P-1:0] m_buf;
  bit           m_bufv, m_lock, m_perr, m_ovf;
  int           m_good;

  sync_frame_controller #(.PAYLOAD_BITS(P), .LOCK_FRAMES(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last4 = 0; m_in_frame = 0; m_frame.delete();
    m_buf = '0; m_bufv = 0; m_lock = 0; m_perr = 0; m_ovf = 0; m_good = 0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic r);
    bit           could_load;
    logic [P-1:0] payload;
    int           ones;
    could_load = !m_bufv || r;
    m_perr = 0;
    if (m_bufv && r) m_bufv = 0;
    if (v) begin
      if (!m_in_frame) begin
        m_last4 = ((m_last4 << 1) | int'(b)) & 15;
        if (m_last4 == 13) begin
          m_in_frame = 1; m_last4 = 0; m_frame.delete();
        end
      end else begin
        m_frame.push_back(b);
        if (m_frame.size() == P + 1) begin
          payload = '0; ones = 0;
          for (int i = 0; i <= P; i++) ones += int'(m_frame[i]);
          for (int i = 0; i < P; i++) payload = {payload[P-2:0], m_frame[i]};
          if (ones % 2 == 0) begin
            m_good = (m_good < L) ? m_good + 1 : L;
            if (could_load) begin m_buf = payload; m_bufv = 1; end
            else m_ovf = 1;
          end else begin
            m_perr = 1; m_good = 0;
          end
          m_lock = (m_good == L);
          m_in_frame = 0; m_last4 = 0; m_frame.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("data_out",   32'(data_out),   32'(m_buf));
    chk("out_valid",  32'(out_valid),  32'(m_bufv));
    chk("locked",     32'(locked),     32'(m_lock));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("overflow",   32'(overflow),   32'(m_ovf));
  endtask

  task automatic step(input logic b, input logic v);
    if (rand_rdy) out_ready = 1'($urandom_range(1));
    in_bit = b; in_valid = v;
    model_step(b, v, out_ready);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_bit = 1'($urandom_range(1)); in_valid = 1'($urandom_range(1)); out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    compare_all();
    rst = 1'b1;
  endtask

  task automatic send_seq(input logic [63:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      while (int'($urandom_range(99)) < gap) step(1'($urandom_range(1)), 1'b0);
      step(v[i], 1'b1);
    end
  endtask

  task automatic send_frame(input logic [P-1:0] pl, input logic par, input int gap);
    send_seq(64'b1101, 4, gap);
    send_seq(64'(pl), P, gap);
    send_seq(64'(par), 1, gap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(1)), 1'b0);
  endtask

  initial begin
    logic [P-1:0] pl;
    rst = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // 1: basic good frame
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(data_out), 0);
    send_frame(8'hA5, 1'b0, 0);
    chk("s1_valid", 32'(out_valid), 1);
    chk("s1_data", 32'(data_out), 32'hA5);
    chk("s1_perr", 32'(parity_err), 0);
    chk("s1_locked", 32'(locked), 0);
    idle(1);
    chk("s1_pulse", 32'(out_valid), 0);

    // 2: bad parity then a good frame immediately
    send_frame(8'hA5, 1'b1, 0);
    chk("s2_perr", 32'(parity_err), 1);
    chk("s2_valid", 32'(out_valid), 0);
    idle(1);
    chk("s2_perr_pulse", 32'(parity_err), 0);
    send_frame(8'h3C, 1'b0, 0);
    chk("s2_valid2", 32'(out_valid), 1);
    chk("s2_data2", 32'(data_out), 32'h3C);

    // 3: lock acquisition and loss
    do_reset();
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    chk("s3_lock2", 32'(locked), 0);
    send_frame(8'h03, 1'b0, 0);
    chk("s3_lock3", 32'(locked), 1);
    send_frame(8'h03, 1'b1, 0);
    chk("s3_unlock", 32'(locked), 0);

    // 4: full buffer drops a frame
    do_reset();
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 0);
    send_frame(8'h5A, 1'b0, 0);
    chk("s4_data", 32'(data_out), 32'hA5);
    chk("s4_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    idle(1);
    chk("s4_drained", 32'(out_valid), 0);
    chk("s4_ovf_sticky", 32'(overflow), 1);

    // 5: overlapping sync with gaps, reload on the drain edge
    do_reset();
    out_ready = 1'b0;
    send_seq(64'b11101, 5, 30);
    send_seq(64'hFF, 8, 30);
    send_seq(64'b0, 1, 30);
    chk("s5_data", 32'(data_out), 32'hFF);
    chk("s5_valid", 32'(out_valid), 1);
    send_seq(64'b1101, 4, 30);
    send_seq(64'h81, 8, 30);
    out_ready = 1'b1;
    step(1'b0, 1'b1);
    chk("s5_keep_valid", 32'(out_valid), 1);
    chk("s5_new_data", 32'(data_out), 32'h81);
    chk("s5_no_ovf", 32'(overflow), 0);
    idle(2);

    // 6: reset mid-payload
    send_seq(64'b1101, 4, 0);
    send_seq(64'b1011, 4, 0);
    do_reset();
    chk("s6_valid", 32'(out_valid), 0);
    chk("s6_data", 32'(data_out), 0);
    chk("s6_locked", 32'(locked), 0);
    chk("s6_ovf", 32'(overflow), 0);
    send_seq(64'b1111, 4, 0);
    chk("s6_no_partial", 32'(out_valid), 0);
    send_frame(8'hC3, 1'b0, 0);
    chk("s6_valid2", 32'(out_valid), 1);
    chk("s6_data2", 32'(data_out), 32'hC3);

    // Randomized frames with junk, gaps, random ready and bad parity
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_seq(64'($urandom), int'($urandom_range(6)), 10);
      pl = P'($urandom);
      send_frame(pl, (^pl) ^ ($urandom_range(3) == 0), 20);
    end
    for (int i = 0; i < 300; i++) step(1'($urandom_range(1)), 1'($urandom_range(1)));
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_frame_controller
`default_nettype wire
